// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB scratch memory: FSM states, lane count
// and the alignment/range error check.
package apb_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_state_t;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Misaligned byte address or word index beyond the stored depth.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] depth,
                                      input logic [63:0] lanes);
        return ((addr % lanes) != 64'd0) || ((addr / lanes) >= depth);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Single-port DEPTH x DATA_WIDTH storage with per-byte write enables and a
// registered read port that can be cleared; the read register is the bus rdata.
import apb_mem_pkg::*;

module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX_W-1:0]        idx,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rd_en,
    input  logic                    rd_clr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read register doubles as the output register, so it clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rdata <= '0;
        else if (rd_clr) rdata <= '0;
        else if (rd_en)  rdata <= mem[idx];
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave scratch memory with programmable wait states and slv_err on
// misaligned/out-of-range transfers. Optional byte strobes: APB_MEM_STRB_EN.
import apb_mem_pkg::*;

module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic                    enable,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef APB_MEM_STRB_EN
    input  logic [DATA_WIDTH/8-1:0] strb,
`endif
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    slv_err
);

    localparam int LANES = byte_lanes(DATA_WIDTH);
    localparam int LSB_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    apb_state_t            state;
    logic [3:0]            cnt;
    logic                  write_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LANES-1:0]      be;

    logic                  setup;
    logic                  err_in;
    logic                  wait_done;
    logic                  rd_en;
    logic                  rd_clr;
    logic                  we;
    logic [IDX_W-1:0]      idx_in;
    logic [IDX_W-1:0]      mem_idx;

    assign setup     = sel && !enable;
    assign idx_in    = addr[LSB_W +: IDX_W];
    assign err_in    = addr_err(64'(addr), 64'(DEPTH), 64'(LANES));
    assign wait_done = (state == WAIT) && sel && (cnt == 4'd0);

    // Memory cannot change while a transfer is pending, so a read issued at the
    // end of WAIT returns what was stored at the setup edge.
    assign rd_en   = ((state == IDLE) && setup && !write && !err_in && (WAIT_STATES == 0))
                  || (wait_done && !write_q && !err_q);
    assign rd_clr  = (state == RESP) || ((state == WAIT) && !sel);
    assign we      = (state == RESP) && sel && write_q && !err_q;
    assign mem_idx = (state == IDLE) ? idx_in : idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            ready   <= 1'b0;
            slv_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        write_q <= write;
                        err_q   <= err_in;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end else begin
                            state   <= RESP;
                            ready   <= 1'b1;
                            slv_err <= err_in;
                        end
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state   <= RESP;
                        ready   <= 1'b1;
                        slv_err <= err_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready   <= 1'b0;
                    slv_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Transfer attributes are captured at setup; access-phase bus changes are ignored.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && setup) begin
            idx_q   <= idx_in;
            wdata_q <= wdata;
`ifdef APB_MEM_STRB_EN
            be      <= strb;
`endif
        end
    end

`ifndef APB_MEM_STRB_EN
    assign be = '1;
`endif

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .idx    (mem_idx),
        .we     (we),
        .be     (be),
        .wdata  (wdata_q),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: instance 0 has no wait states (13-bit address),
// instance 1 has three wait states.
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        sel     [2];
    logic        enable  [2];
    logic        write   [2];
    logic [12:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [3:0]  strb    [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        slv_err [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk     (clk),
        .reset   (rst[0]),
        .sel     (sel[0]),
        .enable  (enable[0]),
        .write   (write[0]),
        .addr    (addr[0]),
        .wdata   (wdata[0]),
`ifdef APB_MEM_STRB_EN
        .strb    (strb[0]),
`endif
        .rdata   (rdata[0]),
        .ready   (ready[0]),
        .slv_err (slv_err[0])
    );

    apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk     (clk),
        .reset   (rst[1]),
        .sel     (sel[1]),
        .enable  (enable[1]),
        .write   (write[1]),
        .addr    (addr[1][11:0]),
        .wdata   (wdata[1]),
`ifdef APB_MEM_STRB_EN
        .strb    (strb[1]),
`endif
        .rdata   (rdata[1]),
        .ready   (ready[1]),
        .slv_err (slv_err[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Full APB transfer; expected response is queued at setup and popped at ready.
    task automatic xfer(input int d, input logic wr, input logic [12:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] er, input logic ee, input string nm);
        exp_t e;
        int   cyc;
        bit   to;
        @(posedge clk); #1;
        sel[d] = 1'b1; enable[d] = 1'b0; write[d] = wr;
        addr[d] = a; wdata[d] = wd; strb[d] = st;
        sbq.push_back('{er, ee, (d == 0) ? 1 : 4});
        @(posedge clk); #1;
        enable[d] = 1'b1;
        addr[d]   = a ^ 13'h004;
        wdata[d]  = ~wd;
        cyc = 1;
        to  = 1'b0;
        @(negedge clk);
        while (!ready[d] && !to) begin
            @(negedge clk);
            cyc++;
            if (cyc > 40) to = 1'b1;
        end
        e = sbq.pop_front();
        if (to) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_ready required=ready", nm);
        end else begin
            chk({nm, "_rdata"}, 64'(rdata[d]), 64'(e.rdata));
            chk({nm, "_err"}, 64'(slv_err[d]), 64'(e.err));
            chk({nm, "_lat"}, 64'(cyc), 64'(e.lat));
        end
        @(posedge clk); #1;
        sel[d] = 1'b0; enable[d] = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, 64'({ready[d], slv_err[d], rdata[d]}), 64'd0);
    endtask

    initial begin
        int hi;

        tbl[0]  = '{1'b1, 13'h000,  32'hA5A5A5A5, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 13'h010,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 13'h010,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 13'h014,  32'h12345678, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 13'h002,  32'hCAFEF00D, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 13'h000,  32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[6]  = '{1'b1, 13'h1000, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 13'h1000, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b1, 13'h0FFC, 32'h0BADC0DE, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 13'h0FFC, 32'h0,        32'h0BADC0DE, 1'b0};
        tbl[10] = '{1'b0, 13'h003,  32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 13'h014,  32'h0,        32'h12345678, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; sel[d] = 1'b0; enable[d] = 1'b0; write[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; strb[d] = 4'hF;
        end
        #2;
        chk("reset0", 64'({ready[0], slv_err[0], rdata[0]}), 64'd0);
        chk("reset3", 64'({ready[1], slv_err[1], rdata[1]}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 12; i++)
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 4'hF, tbl[i].rdata, tbl[i].err,
                 $sformatf("vec%0d", i));

`ifdef APB_MEM_STRB_EN
        xfer(0, 1'b1, 13'h040, 32'h11223344, 4'hF, 32'h0, 1'b0, "strb_init");
        xfer(0, 1'b1, 13'h040, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "strb_0101");
        xfer(0, 1'b0, 13'h040, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "strb_rd1");
        xfer(0, 1'b1, 13'h040, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, "strb_zero");
        xfer(0, 1'b0, 13'h040, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, "strb_rd2");
`endif

        xfer(1, 1'b1, 13'h000, 32'h600DF00D, 4'hF, 32'h0, 1'b0, "ws3_wr0");
        xfer(1, 1'b0, 13'h000, 32'h0, 4'hF, 32'h600DF00D, 1'b0, "ws3_rd0");
        xfer(1, 1'b1, 13'h020, 32'h11111111, 4'hF, 32'h0, 1'b0, "ws3_wr20");
        xfer(1, 1'b1, 13'h006, 32'h22222222, 4'hF, 32'h0, 1'b1, "ws3_misal");

        // Reset while ready is high on a write: outputs clear at once, write dropped.
        @(posedge clk); #1;
        sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1; addr[1] = 13'h020; wdata[1] = 32'h99999999;
        @(posedge clk); #1;
        enable[1] = 1'b1;
        hi = 0;
        for (int c = 0; c < 8 && hi == 0; c++) begin
            @(negedge clk);
            if (ready[1]) hi = 1;
        end
        chk("rst_resp_seen", 64'(hi), 64'd1);
        rst[1] = 1'b1;
        #1;
        chk("rst_resp_clear", 64'({ready[1], slv_err[1], rdata[1]}), 64'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0; sel[1] = 1'b0; enable[1] = 1'b0;
        xfer(1, 1'b0, 13'h020, 32'h0, 4'hF, 32'h11111111, 1'b0, "rst_resp_rd");

        // Reset during WAIT of a write.
        @(posedge clk); #1;
        sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1; addr[1] = 13'h020; wdata[1] = 32'h77777777;
        @(posedge clk); #1;
        enable[1] = 1'b1;
        @(posedge clk); #3;
        rst[1] = 1'b1;
        #1;
        chk("rst_wait_clear", 64'({ready[1], slv_err[1], rdata[1]}), 64'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0; sel[1] = 1'b0; enable[1] = 1'b0;
        xfer(1, 1'b0, 13'h020, 32'h0, 4'hF, 32'h11111111, 1'b0, "rst_wait_rd");

        // Abort: sel drops during WAIT of a write.
        @(posedge clk); #1;
        sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1; addr[1] = 13'h020; wdata[1] = 32'h00000055;
        @(posedge clk); #1;
        enable[1] = 1'b1;
        @(posedge clk); #1;
        sel[1] = 1'b0; enable[1] = 1'b0;
        hi = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready[1]) hi++;
        end
        chk("abort_no_ready", 64'(hi), 64'd0);
        xfer(1, 1'b0, 13'h020, 32'h0, 4'hF, 32'h11111111, 1'b0, "abort_rd");

        // Lone enable without setup is ignored.
        @(posedge clk); #1;
        enable[0] = 1'b1; write[0] = 1'b0; addr[0] = 13'h010;
        hi = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ready[0]) hi++;
        end
        chk("lone_enable", 64'(hi), 64'd0);
        @(posedge clk); #1;
        enable[0] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
